// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator with pixel enable,
//            sync/DE latency compensation, character-cell coordinates,
//            line/frame strobes and a frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 29,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   CNT_W       = 10,
    parameter int   CHAR_W_LOG2 = 3,
    parameter int   CHAR_H_LOG2 = 4,
    parameter int   PIPE_DLY    = 2,
    parameter int   FRM_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_en,
    output logic                         h_sync,
    output logic                         v_sync,
    output logic                         de,
    output logic [CNT_W-1:0]             px_x,
    output logic [CNT_W-1:0]             px_y,
    output logic [CNT_W-CHAR_W_LOG2-1:0] col,
    output logic [CNT_W-CHAR_H_LOG2-1:0] row,
    output logic [CHAR_W_LOG2-1:0]       glyph_x,
    output logic [CHAR_H_LOG2-1:0]       glyph_y,
    output logic                         line_start,
    output logic                         frame_start,
    output logic [FRM_W-1:0]             frame_cnt
);

    localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_h_start = H_SYNC + H_BP;
    localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_v_start = V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_sync_end = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_v_sync_end = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] c_h_act_lo   = CNT_W'(c_h_start);
    localparam logic [CNT_W-1:0] c_h_act_hi   = CNT_W'(c_h_start + H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_act_lo   = CNT_W'(c_v_start);
    localparam logic [CNT_W-1:0] c_v_act_hi   = CNT_W'(c_v_start + V_ACTIVE);

    generate
        if (c_h_total >= (1 << CNT_W)) begin : g_chk_h
            $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
        end
        if (c_v_total >= (1 << CNT_W)) begin : g_chk_v
            $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;
    logic [FRM_W-1:0] r_frm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hc  <= '0;
            r_vc  <= '0;
            r_frm <= '0;
        end else if (pix_en) begin
            if (r_hc == c_h_last) begin
                r_hc <= '0;
                if (r_vc == c_v_last) begin
                    r_vc  <= '0;
                    r_frm <= r_frm + 1'b1;
                end else begin
                    r_vc <= r_vc + 1'b1;
                end
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_act;
    logic [CNT_W-1:0] w_px_x;
    logic [CNT_W-1:0] w_px_y;
    logic             w_line_start;

    assign w_hs_raw = (r_hc < c_h_sync_end) ? HS_POL : ~HS_POL;
    assign w_vs_raw = (r_vc < c_v_sync_end) ? VS_POL : ~VS_POL;
    assign w_act    = (r_hc >= c_h_act_lo) && (r_hc < c_h_act_hi) &&
                      (r_vc >= c_v_act_lo) && (r_vc < c_v_act_hi);

    // Coordinates stay undelayed so a memory fetch of PIPE_DLY ticks lands on de.
    assign w_px_x  = w_act ? (r_hc - c_h_act_lo) : '0;
    assign w_px_y  = w_act ? (r_vc - c_v_act_lo) : '0;
    assign px_x    = w_px_x;
    assign px_y    = w_px_y;
    assign col     = w_px_x[CNT_W-1:CHAR_W_LOG2];
    assign glyph_x = w_px_x[CHAR_W_LOG2-1:0];
    assign row     = w_px_y[CNT_W-1:CHAR_H_LOG2];
    assign glyph_y = w_px_y[CHAR_H_LOG2-1:0];

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign h_sync = rst ? ~HS_POL : w_hs_raw;
            assign v_sync = rst ? ~VS_POL : w_vs_raw;
            assign de     = ~rst & w_act;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] r_hs_pipe;
            logic [PIPE_DLY-1:0] r_vs_pipe;
            logic [PIPE_DLY-1:0] r_de_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hs_pipe <= {PIPE_DLY{~HS_POL}};
                    r_vs_pipe <= {PIPE_DLY{~VS_POL}};
                    r_de_pipe <= '0;
                end else if (pix_en) begin
                    r_hs_pipe <= PIPE_DLY'({r_hs_pipe, w_hs_raw});
                    r_vs_pipe <= PIPE_DLY'({r_vs_pipe, w_vs_raw});
                    r_de_pipe <= PIPE_DLY'({r_de_pipe, w_act});
                end
            end

            assign h_sync = r_hs_pipe[PIPE_DLY-1];
            assign v_sync = r_vs_pipe[PIPE_DLY-1];
            assign de     = r_de_pipe[PIPE_DLY-1];
        end
    endgenerate

    // Qualified by pix_en so each strobe lasts one clk whatever the tick duty.
    assign w_line_start = pix_en & ~rst & (r_hc == '0);
    assign line_start   = w_line_start;
    assign frame_start  = w_line_start & (r_vc == '0);
    assign frame_cnt    = r_frm;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench: reduced-geometry DUT with random pixel
//            enable plus a default-geometry DUT, both against a tick model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, dly, cw, ch, frm_w;
        bit hp, vp;
    } geom_t;

    geom_t g_s, g_d;
    int    n_assert = 0;
    int    n_fail   = 0;

    logic clk = 1'b0;
    logic rst_s, rst_d;
    logic pix_s = 1'b0;
    logic pix_d = 1'b1;

    longint t_s = 0, t_d = 0, cyc = 0;
    longint last_ls_s = -1, last_ls_d = -1;
    bit     alt_mode = 1'b0;
    bit     found;

    always #5 clk = ~clk;

    // Small DUT outputs
    logic       h_sync_s, v_sync_s, de_s, line_start_s, frame_start_s;
    logic [7:0] px_x_s, px_y_s;
    logic [4:0] col_s;
    logic [5:0] row_s;
    logic [2:0] glyph_x_s, frame_cnt_s;
    logic [1:0] glyph_y_s;

    // Default DUT outputs
    logic       h_sync_d, v_sync_d, de_d, line_start_d, frame_start_d;
    logic [9:0] px_x_d, px_y_d;
    logic [6:0] col_d;
    logic [5:0] row_d;
    logic [2:0] glyph_x_d;
    logic [3:0] glyph_y_d;
    logic [7:0] frame_cnt_d;

    vga_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(8),
        .CHAR_W_LOG2(3), .CHAR_H_LOG2(2), .PIPE_DLY(2), .FRM_W(3)
    ) dut_s (
        .clk(clk), .rst(rst_s), .pix_en(pix_s),
        .h_sync(h_sync_s), .v_sync(v_sync_s), .de(de_s),
        .px_x(px_x_s), .px_y(px_y_s), .col(col_s), .row(row_s),
        .glyph_x(glyph_x_s), .glyph_y(glyph_y_s),
        .line_start(line_start_s), .frame_start(frame_start_s),
        .frame_cnt(frame_cnt_s)
    );

    vga_timing_gen #(
        .PIPE_DLY(0)
    ) dut_d (
        .clk(clk), .rst(rst_d), .pix_en(pix_d),
        .h_sync(h_sync_d), .v_sync(v_sync_d), .de(de_d),
        .px_x(px_x_d), .px_y(px_y_d), .col(col_d), .row(row_d),
        .glyph_x(glyph_x_d), .glyph_y(glyph_y_d),
        .line_start(line_start_d), .frame_start(frame_start_d),
        .frame_cnt(frame_cnt_d)
    );

    // Tick counts since reset release: the model's only state.
    always @(posedge clk or posedge rst_s)
        if (rst_s) t_s <= 0; else if (pix_s) t_s <= t_s + 1;
    always @(posedge clk or posedge rst_d)
        if (rst_d) t_d <= 0; else if (pix_d) t_d <= t_d + 1;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int htot(input geom_t g); return g.hs + g.hb + g.ha + g.hf; endfunction
    function automatic int vtot(input geom_t g); return g.vs + g.vb + g.va + g.vf; endfunction
    function automatic int hc_of(input geom_t g, input longint t); return int'(t % htot(g)); endfunction
    function automatic int vc_of(input geom_t g, input longint t); return int'((t / htot(g)) % vtot(g)); endfunction

    function automatic bit in_active(input geom_t g, input longint t);
        int hc, vc;
        hc = hc_of(g, t);
        vc = vc_of(g, t);
        return (hc >= g.hs + g.hb) && (hc < g.hs + g.hb + g.ha) &&
               (vc >= g.vs + g.vb) && (vc < g.vs + g.vb + g.va);
    endfunction

    task automatic lit(input string nm, input longint got, input longint expv);
        n_assert++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    task automatic check_dut(input string nm, input geom_t g, input longint t,
                             input bit r, input bit pe, input logic [68:0] got);
        int hc, vc, px, py, cwd, chd;
        longint fr;
        bit a, hs, vs, dv, ls, fs;
        logic [68:0] expv;
        hc  = hc_of(g, t);
        vc  = vc_of(g, t);
        fr  = (t / (htot(g) * vtot(g))) % (longint'(1) << g.frm_w);
        a   = in_active(g, t);
        px  = a ? hc - (g.hs + g.hb) : 0;
        py  = a ? vc - (g.vs + g.vb) : 0;
        if (r || t < g.dly) begin
            hs = !g.hp; vs = !g.vp; dv = 1'b0;
        end else begin
            hs = (hc_of(g, t - g.dly) < g.hs) ? g.hp : !g.hp;
            vs = (vc_of(g, t - g.dly) < g.vs) ? g.vp : !g.vp;
            dv = in_active(g, t - g.dly);
        end
        ls  = !r && pe && (hc == 0);
        fs  = ls && (vc == 0);
        cwd = 1 << g.cw;
        chd = 1 << g.ch;
        expv = {hs, vs, dv, 12'(px), 12'(py), 12'(px / cwd), 12'(py / chd),
                4'(px % cwd), 4'(py % chd), ls, fs, 8'(fr)};
        n_assert++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h, expected %h", nm, t, got, expv);
        end
    endtask

    always @(negedge clk) begin
        check_dut("small_outputs", g_s, t_s, rst_s, pix_s,
            {h_sync_s, v_sync_s, de_s, 12'(px_x_s), 12'(px_y_s), 12'(col_s), 12'(row_s),
             4'(glyph_x_s), 4'(glyph_y_s), line_start_s, frame_start_s, 8'(frame_cnt_s)});
        check_dut("dflt_outputs", g_d, t_d, rst_d, pix_d,
            {h_sync_d, v_sync_d, de_d, 12'(px_x_d), 12'(px_y_d), 12'(col_d), 12'(row_d),
             4'(glyph_x_d), 4'(glyph_y_d), line_start_d, frame_start_d, 8'(frame_cnt_d)});

        if (!rst_s) begin
            if (t_s == 0 || t_s == 1) lit("s_hsync_inactive", h_sync_s, 0);
            if (t_s == 2)     lit("s_hsync_active", h_sync_s, 1);
            if (t_s == 287)   lit("s_de_before", de_s, 0);
            if (t_s == 288) begin lit("s_de_rise", de_s, 1); lit("s_px_x_288", px_x_s, 2); end
            if (t_s == 327)   lit("s_de_last", de_s, 1);
            if (t_s == 328)   lit("s_de_fall", de_s, 0);
            if (t_s == 11879) lit("s_frm_full", frame_cnt_s, 7);
            if (t_s == 11880) lit("s_frm_wrap", frame_cnt_s, 0);
            if (line_start_s && alt_mode) begin
                if (last_ls_s >= 0) lit("s_line_period_alt", cyc - last_ls_s, 110);
                last_ls_s = cyc;
            end
        end

        if (!rst_d) begin
            if (t_d == 0) begin
                lit("d_frame_start_first", frame_start_d, 1);
                lit("d_hsync_first", h_sync_d, 0);
            end
            if (t_d == 95)   lit("d_hsync_95", h_sync_d, 0);
            if (t_d == 96)   lit("d_hsync_96", h_sync_d, 1);
            if (t_d == 1599) lit("d_vsync_1599", v_sync_d, 0);
            if (t_d == 1600) lit("d_vsync_1600", v_sync_d, 1);
            if (t_d == 30*800 + 200) lit("d_de_vblank", de_d, 0);
            if (t_d == 31*800 + 144) begin lit("d_px_x_start", px_x_d, 0); lit("d_de_start", de_d, 1); end
            if (t_d == 31*800 + 783) begin
                lit("d_px_x_last", px_x_d, 639); lit("d_col_last", col_d, 79); lit("d_de_last", de_d, 1);
            end
            if (t_d == 31*800 + 784) lit("d_de_fp", de_d, 0);
            if (t_d == 66*800 + 161) begin
                lit("d_px_x_161", px_x_d, 17); lit("d_px_y_66", px_y_d, 35);
                lit("d_col", col_d, 2);        lit("d_glyph_x", glyph_x_d, 1);
                lit("d_row", row_d, 2);        lit("d_glyph_y", glyph_y_d, 3);
            end
            if (line_start_d) begin
                if (last_ls_d >= 0) lit("d_line_period", cyc - last_ls_d, 800);
                last_ls_d = cyc;
            end
        end
    end

    initial begin
        g_s.ha = 40;  g_s.hf = 4;  g_s.hs = 6; g_s.hb = 5;
        g_s.va = 20;  g_s.vf = 2;  g_s.vs = 2; g_s.vb = 3;
        g_s.dly = 2;  g_s.cw = 3;  g_s.ch = 2; g_s.frm_w = 3;
        g_s.hp = 1'b1; g_s.vp = 1'b0;
        g_d.ha = 640; g_d.hf = 16; g_d.hs = 96; g_d.hb = 48;
        g_d.va = 480; g_d.vf = 10; g_d.vs = 2;  g_d.vb = 29;
        g_d.dly = 0;  g_d.cw = 3;  g_d.ch = 4;  g_d.frm_w = 8;
        g_d.hp = 1'b0; g_d.vp = 1'b0;

        rst_s = 1'b1;
        rst_d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_s = 1'b0;
        rst_d = 1'b0;
        pix_s = 1'b1;
        repeat (110) @(posedge clk);
        #1;

        alt_mode  = 1'b1;
        last_ls_s = -1;
        for (int i = 0; i < 400; i++) begin
            pix_s = ~pix_s;
            @(posedge clk); #1;
        end
        alt_mode = 1'b0;

        while (t_s < 11900 && cyc < 40000) begin
            pix_s = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        // Park the small DUT mid active line, then reset it between edges.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (hc_of(g_s, t_s) == 30 && vc_of(g_s, t_s) == 10) begin
                found = 1'b1;
            end else begin
                pix_s = 1'b1;
                @(posedge clk); #1;
            end
        end
        pix_s = 1'b0;
        lit("s_reach_mid_line", found, 1);
        @(posedge clk); #2;
        lit("s_pre_rst_de", de_s, 1);
        lit("s_pre_rst_px_x", px_x_s, 19);
        rst_s = 1'b1;
        #1;
        lit("s_async_rst_outputs",
            {h_sync_s, v_sync_s, de_s, px_x_s, px_y_s, line_start_s, frame_start_s, frame_cnt_s},
            {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0});
        @(posedge clk); @(posedge clk); #1;
        rst_s = 1'b0;
        pix_s = 1'b1;

        while (cyc < 53700) begin
            @(posedge clk); #1;
            pix_s = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 counter logic that sits in front of the character/video memory.
- Produces sync, data-enable, pixel coordinates and character-cell coordinates.
- Adds a pixel clock enable, so the block can run from a faster system clock.
- Adds programmable sync polarity, a sync/DE delay line that compensates video-memory read latency, line/frame strobes and a frame counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CNT_W, 10, width of h/v counters and pixel coordinates
- CHAR_W_LOG2, 3, log2 of glyph width (8 px)
- CHAR_H_LOG2, 4, log2 of glyph height (16 lines)
- PIPE_DLY, 2, pixel ticks of delay applied to h_sync/v_sync/de; 0 = none
- FRM_W, 8, frame counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel tick; all timing state advances only on clk edges with pix_en=1
- h_sync  out  1  horizontal sync, delayed PIPE_DLY ticks
- v_sync  out  1  vertical sync, delayed PIPE_DLY ticks
- de  out  1  active-video flag, delayed PIPE_DLY ticks
- px_x  out  CNT_W  active-area column, undelayed
- px_y  out  CNT_W  active-area row, undelayed
- col  out  CNT_W-CHAR_W_LOG2  character column = px_x >> CHAR_W_LOG2
- row  out  CNT_W-CHAR_H_LOG2  character row = px_y >> CHAR_H_LOG2
- glyph_x  out  CHAR_W_LOG2  px_x low bits
- glyph_y  out  CHAR_H_LOG2  px_y low bits
- line_start  out  1  one-clk pulse at hc=0
- frame_start  out  1  one-clk pulse at hc=0, vc=0
- frame_cnt  out  FRM_W  completed-frame count

Behaviour:
- Constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 800); HSTART = H_SYNC+H_BP (144).
  - V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (default 521); VSTART = V_SYNC+V_BP (31).
  - Period order is sync, back porch, active, front porch.
  - Elaboration fails if H_TOTAL or V_TOTAL ≥ 2^CNT_W.
- Counters hc, vc:
  - On pix_en: hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps to 0 after V_TOTAL-1.
  - With pix_en=0, all registers hold.
- Raw timing:
  - hs_raw = (hc < H_SYNC) ? HS_POL : ~HS_POL; vs_raw likewise with V_SYNC and VS_POL.
  - act = HSTART ≤ hc < HSTART+H_ACTIVE and VSTART ≤ vc < VSTART+V_ACTIVE.
- Coordinates:
  - px_x = hc-HSTART and px_y = vc-VSTART when act, else both 0.
  - col/row/glyph_x/glyph_y are slices of px_x/px_y, zero-latency relative to the counters.
  - Memory fetched from these coordinates lines up with de when the fetch latency equals PIPE_DLY ticks.
- Delay line: PIPE_DLY-stage shift registers carry hs_raw, vs_raw and act; each stage shifts only on pix_en.
- Strobes:
  - line_start = pix_en & (hc==0); frame_start = pix_en & (hc==0) & (vc==0).
  - Each is high for exactly one clk per line/frame, regardless of pix_en duty cycle.
- frame_cnt increments on the pix_en tick where hc=H_TOTAL-1 and vc=V_TOTAL-1; it wraps modulo 2^FRM_W.
- Reset (async assert, any time including mid-line):
  - hc=vc=0, frame_cnt=0.
  - All delay stages at inactive levels: sync = ~POL, de=0.
  - h_sync/v_sync = ~POL, de=0, line_start = frame_start = 0 while rst is high.
- After rst release:
  - The first pix_en edge evaluates hc=0/vc=0, so frame_start and line_start pulse.
  - h_sync/v_sync reach the active level after PIPE_DLY ticks.

Test Plan:
1. Defaults with PIPE_DLY=0, pix_en tied 1, reset released → h_sync low for hc 0..95; line period 800 clk; v_sync low for the first 1600 clk of each frame; frame period 416800 clk.
2. Defaults (PIPE_DLY=2) → px_x=0 when hc=144; de rises 2 clks later; de stays high 640 clks per active line; de low for vc<31 and vc≥511.
3. Coordinates at hc=161, vc=66 → px_x=17, px_y=35, col=2, glyph_x=1, row=2, glyph_y=3; at hc=783 → px_x=639, col=79.
4. pix_en alternating 1/0 → line period 1600 clk; counters and syncs hold on pix_en=0 cycles; line_start high exactly 1 clk per line.
5. frame_cnt preloaded by running 255 frames → reads 0xFF; at the next frame wrap → 0x00, coincident with the following frame_start tick.
6. Assert rst asynchronously at hc=500, vc=200 → outputs go to reset values immediately without a clock edge; after release, hc restarts at 0; frame_start pulses on the first pix_en; h_sync goes low 2 ticks later.
